// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit counters, ID-stage
// prediction tracking, mispredict flush/redirect and saturating statistics.
module branch_predictor #(
    parameter int MAX_LENGTH = 32,
    parameter int INDEX_BITS = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic [MAX_LENGTH-1:0] if_pc,
    output logic                  pred_taken,
    output logic [MAX_LENGTH-1:0] pred_target,
    input  logic                  id_valid,
    input  logic [MAX_LENGTH-1:0] id_pc,
    input  logic                  id_is_branch,
    input  logic                  id_taken,
    input  logic [MAX_LENGTH-1:0] id_target,
    output logic                  flush,
    output logic [MAX_LENGTH-1:0] redirect_pc,
    output logic [CNT_WIDTH-1:0]  branch_count,
    output logic [CNT_WIDTH-1:0]  mispredict_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = MAX_LENGTH - INDEX_BITS - 2;

    logic                  valid_q  [ENTRIES];
    logic [TAG_W-1:0]      tag_q    [ENTRIES];
    logic [MAX_LENGTH-1:0] target_q [ENTRIES];
    logic [1:0]            ctr_q    [ENTRIES];

    logic                  id_pred_taken;
    logic [MAX_LENGTH-1:0] id_pred_target;

    logic [INDEX_BITS-1:0] if_idx;
    logic [TAG_W-1:0]      if_tag;
    logic                  if_hit;
    logic [INDEX_BITS-1:0] id_idx;
    logic [TAG_W-1:0]      id_tag;
    logic                  id_hit;
    logic                  train;
    logic                  mispredict;
    logic                  unused_pc_bits;

    // Word-aligned PCs: the two low bits never select or tag an entry.
    assign unused_pc_bits = ^{if_pc[1:0], id_pc[1:0]};

    assign if_idx = if_pc[INDEX_BITS+1:2];
    assign if_tag = if_pc[MAX_LENGTH-1:INDEX_BITS+2];
    assign id_idx = id_pc[INDEX_BITS+1:2];
    assign id_tag = id_pc[MAX_LENGTH-1:INDEX_BITS+2];

    assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign id_hit      = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
    assign pred_taken  = if_hit && ctr_q[if_idx][1];
    assign pred_target = pred_taken ? target_q[if_idx] : '0;

    assign train = rst && !freeze && id_valid;

    always_comb begin
        mispredict = 1'b0;
        if (train) begin
            if (id_is_branch) begin
                mispredict = (id_taken != id_pred_taken) ||
                             (id_taken && (id_target != id_pred_target));
            end else begin
                mispredict = id_pred_taken;
            end
        end
    end

    assign flush       = mispredict;
    assign redirect_pc = (id_is_branch && id_taken) ? id_target
                                                    : id_pc + MAX_LENGTH'(4);

    // Tracking registers: a flush pushes a bubble into ID, so it wins over freeze.
    always_ff @(posedge clk) begin
        if (!rst) begin
            id_pred_taken  <= 1'b0;
            id_pred_target <= '0;
        end else if (flush) begin
            id_pred_taken  <= 1'b0;
            id_pred_target <= '0;
        end else if (!freeze) begin
            id_pred_taken  <= pred_taken;
            id_pred_target <= pred_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'd1;
            end
        end else if (train) begin
            if (id_is_branch) begin
                if (id_hit) begin
                    if (id_taken) begin
                        target_q[id_idx] <= id_target;
                        if (ctr_q[id_idx] != 2'd3) begin
                            ctr_q[id_idx] <= ctr_q[id_idx] + 2'd1;
                        end
                    end else if (ctr_q[id_idx] != 2'd0) begin
                        ctr_q[id_idx] <= ctr_q[id_idx] - 2'd1;
                    end
                end else begin
                    // New entries start weakly biased toward the observed outcome.
                    valid_q[id_idx]  <= 1'b1;
                    tag_q[id_idx]    <= id_tag;
                    target_q[id_idx] <= id_target;
                    ctr_q[id_idx]    <= id_taken ? 2'd2 : 2'd1;
                end
            end else if (id_pred_taken) begin
                valid_q[id_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (train && id_is_branch && (branch_count != '1)) begin
                branch_count <= branch_count + 1'b1;
            end
            if (flush && (mispredict_count != '1)) begin
                mispredict_count <= mispredict_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized scoreboard bench for branch_predictor against a table-level
// reference model of the predictor rules.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        id_valid;
    logic [31:0] id_pc;
    logic        id_is_branch;
    logic        id_taken;
    logic [31:0] id_target;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [15:0] branch_count;
    logic [15:0] mispredict_count;

    always #5 clk = ~clk;

    branch_predictor #(.MAX_LENGTH(32), .INDEX_BITS(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .id_valid(id_valid), .id_pc(id_pc), .id_is_branch(id_is_branch),
        .id_taken(id_taken), .id_target(id_target), .flush(flush),
        .redirect_pc(redirect_pc), .branch_count(branch_count),
        .mispredict_count(mispredict_count)
    );

    typedef struct {
        logic        pt;
        logic [31:0] ptgt;
        logic        fl;
        logic [31:0] rpc;
        int          bc;
        int          mc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int total = 0;
    int bad   = 0;

    // Reference model: the BTB as plain arrays with integer counters.
    logic        m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    logic        m_idpt;
    logic [31:0] m_idtgt;
    int          m_bc;
    int          m_mc;

    logic [31:0] pc_pool [8] = '{32'h40, 32'h44, 32'h48, 32'h80,
                                 32'h440, 32'h444, 32'h3c, 32'hFFFF_FFFC};
    logic [31:0] tgt_pool [3] = '{32'h100, 32'h200, 32'h300};

    function automatic void lookup(input logic [31:0] pc, output logic t,
                                   output logic [31:0] g);
        int i;
        i = int'(pc[5:2]);
        t = m_valid[i] && (m_tag[i] == pc[31:6]) && (m_ctr[i] >= 2);
        g = t ? m_tgt[i] : 32'h0;
    endfunction

    function automatic logic model_mis();
        if (!rst || freeze || !id_valid) return 1'b0;
        if (id_is_branch)
            return (id_taken != m_idpt) || (id_taken && id_target != m_idtgt);
        return m_idpt;
    endfunction

    // Applies what the rising edge does with the inputs held during the cycle.
    task automatic model_edge();
        logic        pt;
        logic [31:0] pg;
        logic        mis;
        int          i;
        if (!rst) begin
            for (int k = 0; k < 16; k++) begin
                m_valid[k] = 1'b0; m_tag[k] = '0; m_tgt[k] = '0; m_ctr[k] = 1;
            end
            m_idpt = 1'b0; m_idtgt = '0; m_bc = 0; m_mc = 0;
            return;
        end
        lookup(if_pc, pt, pg);
        mis = model_mis();
        i = int'(id_pc[5:2]);
        if (!freeze && id_valid) begin
            if (id_is_branch) begin
                if (m_valid[i] && m_tag[i] == id_pc[31:6]) begin
                    if (id_taken) begin
                        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                        m_tgt[i] = id_target;
                    end else begin
                        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                    end
                end else begin
                    m_valid[i] = 1'b1;
                    m_tag[i]   = id_pc[31:6];
                    m_tgt[i]   = id_target;
                    m_ctr[i]   = id_taken ? 2 : 1;
                end
                if (m_bc < 65535) m_bc++;
            end else if (m_idpt) begin
                m_valid[i] = 1'b0;
            end
        end
        if (mis && m_mc < 65535) m_mc++;
        if (mis) begin
            m_idpt = 1'b0; m_idtgt = '0;
        end else if (!freeze) begin
            m_idpt = pt; m_idtgt = pg;
        end
    endtask

    task automatic step(input logic r, input logic fz, input logic [31:0] ipc,
                        input logic v, input logic [31:0] dpc, input logic br,
                        input logic tk, input logic [31:0] tg);
        exp_t x;
        @(posedge clk);
        model_edge();
        #1;
        rst = r; freeze = fz; if_pc = ipc; id_valid = v; id_pc = dpc;
        id_is_branch = br; id_taken = tk; id_target = tg;
        lookup(if_pc, x.pt, x.ptgt);
        x.fl  = model_mis();
        x.rpc = (br && tk) ? tg : dpc + 32'd4;
        x.bc  = m_bc;
        x.mc  = m_mc;
        sb.push_back(x);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("pred_taken", {31'b0, pred_taken}, {31'b0, e.pt});
            check("pred_target", pred_target, e.ptgt);
            check("flush", {31'b0, flush}, {31'b0, e.fl});
            if (e.fl) check("redirect_pc", redirect_pc, e.rpc);
            check("branch_count", {16'b0, branch_count}, e.bc);
            check("mispredict_count", {16'b0, mispredict_count}, e.mc);
        end
    end

    initial begin
        logic [31:0] prev_if;
        logic [31:0] nif;
        rst = 1'b0; freeze = 1'b0; if_pc = '0; id_valid = 1'b0; id_pc = '0;
        id_is_branch = 1'b0; id_taken = 1'b0; id_target = '0;
        for (int k = 0; k < 16; k++) begin
            m_valid[k] = 1'b0; m_tag[k] = '0; m_tgt[k] = '0; m_ctr[k] = 1;
        end
        m_idpt = 1'b0; m_idtgt = '0; m_bc = 0; m_mc = 0;

        // Directed walk: cold miss, warm hits, counter decay, target change, alias.
        step(0, 0, 32'h40, 0, 32'h0, 0, 0, 32'h0);
        step(0, 0, 32'h40, 0, 32'h0, 0, 0, 32'h0);
        step(1, 0, 32'h40, 0, 32'h0, 0, 0, 32'h0);
        step(1, 0, 32'h44, 1, 32'h40, 1, 1, 32'h100);
        step(1, 0, 32'h40, 0, 32'h0, 0, 0, 32'h0);
        step(1, 0, 32'h40, 1, 32'h40, 1, 1, 32'h100);
        step(1, 0, 32'h40, 1, 32'h40, 1, 0, 32'h100);
        step(1, 0, 32'h40, 1, 32'h40, 1, 0, 32'h100);
        step(1, 0, 32'h40, 1, 32'h40, 1, 0, 32'h100);
        step(1, 0, 32'h40, 1, 32'h40, 1, 1, 32'h100);
        step(1, 0, 32'h40, 1, 32'h40, 1, 1, 32'h100);
        step(1, 0, 32'h40, 1, 32'h40, 1, 1, 32'h100);
        step(1, 0, 32'h40, 1, 32'h40, 1, 1, 32'h200);
        step(1, 0, 32'h40, 0, 32'h0, 0, 0, 32'h0);
        step(1, 0, 32'h48, 1, 32'h40, 0, 0, 32'h0);
        step(1, 0, 32'h40, 1, 32'h48, 0, 0, 32'h0);
        step(1, 0, 32'h40, 1, 32'h40, 1, 1, 32'h200);
        step(1, 1, 32'h40, 1, 32'h40, 1, 0, 32'h200);
        step(1, 0, 32'h40, 1, 32'h40, 1, 0, 32'h200);
        step(0, 0, 32'h40, 1, 32'h40, 1, 1, 32'h300);
        step(1, 0, 32'h40, 0, 32'h0, 0, 0, 32'h0);

        prev_if = if_pc;
        for (int n = 0; n < 3000; n++) begin
            nif = pc_pool[$urandom_range(0, 7)];
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 9) == 0),
                 nif,
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 9) < 8) ? prev_if : pc_pool[$urandom_range(0, 7)],
                 ($urandom_range(0, 9) < 8),
                 1'($urandom_range(0, 1)),
                 tgt_pool[$urandom_range(0, 2)]);
            prev_if = nif;
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side consumer of the ID-stage branch resolution (condition result, target, branch/jump class).
- Predicts next PC at fetch from a direct-mapped branch target buffer with 2-bit saturating counters.
- Tracks the prediction made for the instruction now in ID.
- On resolution it raises flush plus a corrected PC on mispredict, trains the table, and counts branches and mispredicts.

Parameters:
- MAX_LENGTH, 32, datapath/PC width (matches global define).
- INDEX_BITS, 4, BTB index width; 2**INDEX_BITS entries, indexed by pc[INDEX_BITS+1:2].
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low (asserted when 0, sampled on rising clk).
- freeze  in  1  pipeline stall; holds ID tracking state, suppresses training and redirect.
- if_pc  in  MAX_LENGTH  PC currently being fetched.
- pred_taken  out  1  combinational fetch prediction.
- pred_target  out  MAX_LENGTH  combinational predicted target; 0 when pred_taken=0.
- id_valid  in  1  ID stage holds a real instruction (not a bubble).
- id_pc  in  MAX_LENGTH  PC of the ID instruction.
- id_is_branch  in  1  ID instruction is jump/BEZ/BNE.
- id_taken  in  1  resolved outcome (branch condition check result).
- id_target  in  MAX_LENGTH  resolved target address.
- flush  out  1  combinational; squash the IF/ID instruction.
- redirect_pc  out  MAX_LENGTH  corrected next PC, valid when flush=1.
- branch_count  out  CNT_WIDTH  resolved branches, saturating.
- mispredict_count  out  CNT_WIDTH  mispredicts, saturating.

Behaviour:
- BTB entry fields: valid, tag = pc[MAX_LENGTH-1:INDEX_BITS+2], target, 2-bit counter.
- Lookup: hit = valid && tag match. pred_taken = hit && ctr[1]. pred_target = target if pred_taken, else 0.
- ID tracking registers id_pred_taken and id_pred_target update on each rising edge:
  - rst=0: both cleared.
  - flush=1: load 0 (bubble enters ID).
  - freeze=1: hold.
  - otherwise: load pred_taken and pred_target.
- Mispredict (combinational), active only when rst=1, freeze=0, id_valid=1:
  - branch with id_taken != id_pred_taken; or
  - branch with id_taken=1 and id_target != id_pred_target; or
  - non-branch with id_pred_taken=1 (alias).
- flush = mispredict. redirect_pc = id_target if (id_is_branch && id_taken), else id_pc+4 (mod 2**MAX_LENGTH).
- Training on rising edge when rst=1, freeze=0, id_valid=1, at index from id_pc:
  - Branch hit: taken → ctr++ saturating at 3, target <= id_target; not-taken → ctr-- saturating at 0.
  - Branch miss: allocate (overwrite) with valid=1, tag, target=id_target, ctr=2 if taken else 1.
  - Non-branch with id_pred_taken=1: clear that entry's valid.
- Same-index fetch read and ID write in one cycle: lookup sees the pre-write value; no bypass.
- Statistics: when training occurs for a branch, branch_count++. When flush=1, mispredict_count++. Both saturate at all-ones.
- Reset (rst=0 at edge): all valid=0, all ctr=1, targets/tags=0, counts=0, tracking regs=0.
  - During reset cycles flush=0 and no training occurs.
  - Reset mid-operation discards any pending resolution.
- Outputs after reset: pred_taken=0, pred_target=0, flush=0, redirect_pc=id_pc+4 (don't-care), counts=0.

Test Plan:
- Cold taken branch: after reset, fetch 0x40 (pred_taken=0). Next cycle id_pc=0x40, branch, taken, target 0x100 → flush=1, redirect_pc=0x100, entry 0 ctr=2, branch_count=1, mispredict_count=1.
- Warm hit: refetch 0x40 → pred_taken=1, pred_target=0x100. Taken again in ID → flush=0, ctr=3. Three not-taken resolutions → ctr 3→2→1→0; pred_taken drops after the second one.
- Not-taken mispredict: ctr=2 entry predicted taken, id_taken=0, id_pc=0x40 → flush=1, redirect_pc=0x44.
- Target change: hit with target 0x100, resolve taken to 0x200 → flush=1, redirect_pc=0x200, target updated; next fetch predicts 0x200.
- Alias: non-branch at 0x440 (same index/tag? tag differs → miss). Force a tag-matching non-branch predicted taken → flush=1, redirect_pc=id_pc+4, entry invalidated.
- Freeze and reset: freeze=1 during a mispredicting resolution → flush=0, no table or count change; releasing freeze → flush=1. Assert rst=0 mid-stream → all counts 0, next lookup misses.
